// File: rtl/adder_result_checker.sv
// adder_result_checker
// Registered, self-counting checker that sits after a DUV adder and a
// reference adder. It compares each accepted vector and counts vectors and
// failures. It keeps the first failing vector and reports done/pass once
// NUM_VECTORS vectors have been accepted.
// Optional build macro: CHECKER_STOP_ON_ERR_EN. When it is defined, the run
// ends at the first failing vector.
module adder_result_checker #(
  parameter int N           = 16,
  parameter int TYPE        = 1,
  parameter int NUM_VECTORS = 30000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             cin,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [N-1:0]     s_ref,
  input  logic [N-1:0]     s_duv,
  input  logic             cout_ref,
  input  logic             cout_duv,
  input  logic             prop_ref,
  input  logic             prop_duv,
  input  logic             gen_ref,
  input  logic             gen_duv,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [N-1:0]     first_err_a,
  output logic [N-1:0]     first_err_b,
  output logic             first_err_cin
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic             CMP_PG   = (TYPE == 32'sd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_VECTORS);

  // A vector fails when any compared result bit differs from the reference.
  function automatic logic vec_fails(
    input logic [N-1:0] sr,
    input logic [N-1:0] sd,
    input logic         cr,
    input logic         cd,
    input logic         pr,
    input logic         pd,
    input logic         gr,
    input logic         gd
  );
    logic f;
    f = (sr != sd) | (cr != cd);
    if (CMP_PG) begin
      f = f | (pr != pd) | (gr != gd);
    end else begin
      f = f;
    end
    return f;
  endfunction

  state_t           state_r, state_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             done_r, done_nxt_s;
  logic             pass_r, pass_nxt_s;
  logic             mismatch_r, mismatch_nxt_s;
  logic [CNT_W-1:0] vec_count_r, vec_count_nxt_s;
  logic [CNT_W-1:0] err_count_r, err_count_nxt_s;
  logic             fev_r, fev_nxt_s;
  logic [CNT_W-1:0] fidx_r, fidx_nxt_s;
  logic [N-1:0]     fa_r, fa_nxt_s;
  logic [N-1:0]     fb_r, fb_nxt_s;
  logic             fcin_r, fcin_nxt_s;
  logic             fail_s;
  logic             stop_en_s;

`ifdef CHECKER_STOP_ON_ERR_EN
  assign stop_en_s = 1'b1;
`else
  assign stop_en_s = 1'b0;
`endif

  assign fail_s = vec_fails(s_ref, s_duv, cout_ref, cout_duv,
                            prop_ref, prop_duv, gen_ref, gen_duv);

  // Next-state, counter and capture logic; the registered outputs follow from the next state.
  always_comb begin
    state_nxt_s     = state_r;
    mismatch_nxt_s  = 1'b0;
    vec_count_nxt_s = vec_count_r;
    err_count_nxt_s = err_count_r;
    fev_nxt_s       = fev_r;
    fidx_nxt_s      = fidx_r;
    fa_nxt_s        = fa_r;
    fb_nxt_s        = fb_r;
    fcin_nxt_s      = fcin_r;

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt_s     = ST_RUN;
          vec_count_nxt_s = CNT_ZERO;
          err_count_nxt_s = CNT_ZERO;
          fev_nxt_s       = 1'b0;
          fidx_nxt_s      = CNT_ZERO;
          fa_nxt_s        = {N{1'b0}};
          fb_nxt_s        = {N{1'b0}};
          fcin_nxt_s      = 1'b0;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          vec_count_nxt_s = vec_count_r + CNT_ONE;
          mismatch_nxt_s  = fail_s;
          if (fail_s && (err_count_r != CNT_MAX)) begin
            err_count_nxt_s = err_count_r + CNT_ONE;
          end else begin
            err_count_nxt_s = err_count_r;
          end
          // Only the first failure of a run is captured; later ones leave it alone.
          if (fail_s && !fev_r) begin
            fev_nxt_s  = 1'b1;
            fidx_nxt_s = vec_count_r;
            fa_nxt_s   = a;
            fb_nxt_s   = b;
            fcin_nxt_s = cin;
          end else begin
            fev_nxt_s = fev_r;
          end
          if ((vec_count_nxt_s == CNT_LAST) || (stop_en_s && fail_s)) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    busy_nxt_s = (state_nxt_s == ST_RUN);
    done_nxt_s = (state_nxt_s == ST_DONE);
    pass_nxt_s = done_nxt_s && (err_count_nxt_s == CNT_ZERO);
  end

  // State and result registers; reset clears everything and returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      mismatch_r  <= 1'b0;
      vec_count_r <= CNT_ZERO;
      err_count_r <= CNT_ZERO;
      fev_r       <= 1'b0;
      fidx_r      <= CNT_ZERO;
      fa_r        <= {N{1'b0}};
      fb_r        <= {N{1'b0}};
      fcin_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      pass_r      <= pass_nxt_s;
      mismatch_r  <= mismatch_nxt_s;
      vec_count_r <= vec_count_nxt_s;
      err_count_r <= err_count_nxt_s;
      fev_r       <= fev_nxt_s;
      fidx_r      <= fidx_nxt_s;
      fa_r        <= fa_nxt_s;
      fb_r        <= fb_nxt_s;
      fcin_r      <= fcin_nxt_s;
    end
  end

  assign busy            = busy_r;
  assign done            = done_r;
  assign pass            = pass_r;
  assign mismatch        = mismatch_r;
  assign vec_count       = vec_count_r;
  assign err_count       = err_count_r;
  assign first_err_valid = fev_r;
  assign first_err_idx   = fidx_r;
  assign first_err_a     = fa_r;
  assign first_err_b     = fb_r;
  assign first_err_cin   = fcin_r;

endmodule

// File: tb/tb_adder_result_checker.sv
// Bench for adder_result_checker: a TYPE=1 and a TYPE=0 instance share the
// stimulus. The expected state of the TYPE=1 instance is pushed to a
// scoreboard queue each cycle and checked after the edge.
module tb_adder_result_checker;

`ifdef CHECKER_STOP_ON_ERR_EN
  localparam logic STOP_EN = 1'b1;
`else
  localparam logic STOP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, in_valid, cin;
  logic [15:0] a, b, s_ref, s_duv;
  logic cout_ref, cout_duv, prop_ref, prop_duv, gen_ref, gen_duv;

  logic busy, done, pass, mismatch, fev, fcin;
  logic [15:0] vec_count, err_count, fidx, fa, fb;
  logic busy0, done0, pass0, mismatch0, fev0, fcin0;
  logic [15:0] vec_count0, err_count0, fidx0, fa0, fb0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        mis;
    logic [15:0] vec;
    logic [15:0] err;
    logic        done;
    logic        busy;
    logic        pass;
    logic        fev;
  } exp_t;
  exp_t sb_q[$];

  int m_state;  // 0 idle, 1 run, 2 done
  int m_vec;
  int m_err;
  logic m_fev;

  always #5 clk = ~clk;

  adder_result_checker #(.N(16), .TYPE(1), .NUM_VECTORS(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .cin(cin),
    .a(a), .b(b), .s_ref(s_ref), .s_duv(s_duv), .cout_ref(cout_ref), .cout_duv(cout_duv),
    .prop_ref(prop_ref), .prop_duv(prop_duv), .gen_ref(gen_ref), .gen_duv(gen_duv),
    .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
    .vec_count(vec_count), .err_count(err_count), .first_err_valid(fev),
    .first_err_idx(fidx), .first_err_a(fa), .first_err_b(fb), .first_err_cin(fcin));

  adder_result_checker #(.N(16), .TYPE(0), .NUM_VECTORS(4), .CNT_W(16)) u_dut_t0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .cin(cin),
    .a(a), .b(b), .s_ref(s_ref), .s_duv(s_duv), .cout_ref(cout_ref), .cout_duv(cout_duv),
    .prop_ref(prop_ref), .prop_duv(prop_duv), .gen_ref(gen_ref), .gen_duv(gen_duv),
    .busy(busy0), .done(done0), .pass(pass0), .mismatch(mismatch0),
    .vec_count(vec_count0), .err_count(err_count0), .first_err_valid(fev0),
    .first_err_idx(fidx0), .first_err_a(fa0), .first_err_b(fb0), .first_err_cin(fcin0));

  // Drive one cycle of stimulus, push the expected outcome, then score it after the edge.
  task automatic step(input logic v, input logic st, input logic c,
                      input logic [15:0] aa, input logic [15:0] bb,
                      input logic [15:0] sflt, input logic gflt);
    logic [16:0] sum;
    logic [16:0] gsum;
    logic        mis;
    exp_t        e;
    sum  = {1'b0, aa} + {1'b0, bb} + {16'd0, c};
    gsum = {1'b0, aa} + {1'b0, bb};
    in_valid = v; start = st; cin = c; a = aa; b = bb;
    s_ref = sum[15:0]; s_duv = sum[15:0] ^ sflt;
    cout_ref = sum[16]; cout_duv = sum[16];
    prop_ref = &(aa ^ bb); prop_duv = &(aa ^ bb);
    gen_ref = gsum[16]; gen_duv = gsum[16] ^ gflt;
    mis = 1'b0;
    if (m_state == 1) begin
      if (v) begin
        m_vec = m_vec + 1;
        mis = (sflt != 16'd0) || gflt;
        if (mis) begin
          m_err = m_err + 1;
          m_fev = 1'b1;
        end
        if ((m_vec == 4) || (STOP_EN && mis)) m_state = 2;
      end
    end else if (st) begin
      m_state = 1; m_vec = 0; m_err = 0; m_fev = 1'b0;
    end
    e.mis = mis; e.vec = 16'(m_vec); e.err = 16'(m_err);
    e.done = (m_state == 2); e.busy = (m_state == 1);
    e.pass = (m_state == 2) && (m_err == 0); e.fev = m_fev;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++;
    if ({mismatch, vec_count, err_count, done, busy, pass, fev} !==
        {e.mis, e.vec, e.err, e.done, e.busy, e.pass, e.fev}) begin
      errors++;
      $display("FAIL scoreboard t=%0t: got mis=%b vec=%0d err=%0d done=%b busy=%b pass=%b fev=%b, expected mis=%b vec=%0d err=%0d done=%b busy=%b pass=%b fev=%b",
               $time, mismatch, vec_count, err_count, done, busy, pass, fev,
               e.mis, e.vec, e.err, e.done, e.busy, e.pass, e.fev);
    end
  endtask

  task automatic model_clear();
    m_state = 0; m_vec = 0; m_err = 0; m_fev = 1'b0;
    sb_q.delete();
  endtask

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; cin = 1'b0;
    a = 16'd0; b = 16'd0; s_ref = 16'd0; s_duv = 16'd0;
    cout_ref = 1'b0; cout_duv = 1'b0; prop_ref = 1'b0; prop_duv = 1'b0;
    gen_ref = 1'b0; gen_duv = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic clean_vectors(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'($urandom_range(1, 0)), 16'($urandom), 16'($urandom), 16'd0, 1'b0);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({busy, done, pass, mismatch, vec_count, err_count, fev, fidx, fa, fb, fcin,
         busy0, done0, pass0, mismatch0, vec_count0, err_count0, fev0, fidx0, fa0, fb0, fcin0} !== 180'd0) begin
      errors++;
      $display("FAIL reset_state: outputs not all zero (busy=%b done=%b vec=%0d err=%0d), expected 0", busy, done, vec_count, err_count);
    end
  endtask

  task automatic test_clean_run();
    apply_reset();
    step(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
    clean_vectors(4);
    checks++;
    if ({done, pass, vec_count, err_count, fev} !== {1'b1, 1'b1, 16'd4, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL clean_run: done=%b pass=%b vec=%0d err=%0d fev=%b, expected 1 1 4 0 0", done, pass, vec_count, err_count, fev);
    end
  endtask

  task automatic test_single_fault();
    apply_reset();
    step(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
    clean_vectors(2);
    step(1'b1, 1'b0, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0);
    clean_vectors(1);
    checks++;
    if ({done, pass, err_count, fev, fidx, fa, fb, fcin} !==
        {1'b1, 1'b0, 16'd1, 1'b1, 16'd2, 16'h00FF, 16'h0001, 1'b0}) begin
      errors++;
      $display("FAIL single_fault: done=%b pass=%b err=%0d fev=%b idx=%0d a=%h b=%h cin=%b, expected 1 0 1 1 2 00ff 0001 0",
               done, pass, err_count, fev, fidx, fa, fb, fcin);
    end
  endtask

  task automatic test_type_gating();
    apply_reset();
    step(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
    clean_vectors(1);
    step(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'd0, 1'b1);
    clean_vectors(2);
    checks++;
    if ({done, pass, err_count} !== {1'b1, 1'b0, 16'd1}) begin
      errors++;
      $display("FAIL type1_gen: done=%b pass=%b err=%0d, expected 1 0 1", done, pass, err_count);
    end
    checks++;
    if ({done0, pass0, err_count0, vec_count0, mismatch0} !== {1'b1, 1'b1, 16'd0, 16'd4, 1'b0}) begin
      errors++;
      $display("FAIL type0_gen: done=%b pass=%b err=%0d vec=%0d, expected 1 1 0 4", done0, pass0, err_count0, vec_count0);
    end
  endtask

  task automatic test_gaps();
    apply_reset();
    step(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'((i % 2) == 0), 1'(i == 3), 1'b1, 16'($urandom), 16'($urandom), 16'd0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0, 16'h1234, 16'h4321, 16'hFFFF, 1'b0);
    checks++;
    if ({done, vec_count, err_count, mismatch} !== {1'b1, 16'd4, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL gaps_done: done=%b vec=%0d err=%0d mis=%b, expected 1 4 0 0", done, vec_count, err_count, mismatch);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    step(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 16'(i * 7), 16'd3, 16'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'd5, 16'd6, 16'd0, 1'b0);
    checks++;
    if ({busy, done, vec_count} !== {1'b1, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL restart_from_done: busy=%b done=%b vec=%0d, expected 1 0 0", busy, done, vec_count);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 16'(i * 11), 16'd9, 16'd0, 1'b0);
  endtask

  task automatic test_async_reset();
    apply_reset();
    step(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0001, 16'h0002, 16'h0001, 1'b0);
    clean_vectors(1);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, pass, mismatch, vec_count, err_count, fev, fidx, fa, fb, fcin} !== 90'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%b vec=%0d err=%0d fev=%b, expected all 0", busy, vec_count, err_count, fev);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    step(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
    clean_vectors(4);
    checks++;
    if ({pass, vec_count} !== {1'b1, 16'd4}) begin
      errors++;
      $display("FAIL restart_after_reset: pass=%b vec=%0d, expected 1 4", pass, vec_count);
    end
  endtask

  task automatic test_stop_on_err();
    apply_reset();
    step(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
    clean_vectors(1);
    step(1'b1, 1'b0, 1'b1, 16'h0F0F, 16'hF0F0, 16'h8000, 1'b0);
    checks++;
    if ({done, vec_count, err_count, mismatch, fidx} !== {STOP_EN, 16'd2, 16'd1, 1'b1, 16'd1}) begin
      errors++;
      $display("FAIL stop_on_err: done=%b vec=%0d err=%0d mis=%b idx=%0d, expected %b 2 1 1 1",
               done, vec_count, err_count, mismatch, fidx, STOP_EN);
    end
    clean_vectors(3);
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_single_fault();
    test_type_gating();
    test_gaps();
    test_back_to_back();
    test_async_reset();
    test_stop_on_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
